// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : hazard_pkg                                                   |
// | Description : Shared defaults and helpers for the pending-write scoreboard: |
// |               default latencies/widths, counter-width and latency-select   |
// |               functions.                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hazard_pkg;

  localparam int DEF_REG_ADDR_W  = 4;
  localparam int DEF_NOFWD_LAT   = 2;
  localparam int DEF_FWD_ALU_LAT = 0;
  localparam int DEF_FWD_LD_LAT  = 1;
  localparam int DEF_STALL_CNT_W = 16;

  // Width needed to hold the largest latency; never narrower than one bit so
  // an all-zero latency configuration still elaborates.
  function automatic int cnt_w(input int nofwd, input int fwd_alu, input int fwd_ld);
    int m;
    m = nofwd;
    if (fwd_alu > m) m = fwd_alu;
    if (fwd_ld > m) m = fwd_ld;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Cycles the freshly issued result stays unavailable to younger readers.
  function automatic int sel_lat(input logic fwd_en, input logic is_load,
                                 input int nofwd, input int fwd_alu, input int fwd_ld);
    if (!fwd_en) return nofwd;
    return is_load ? fwd_ld : fwd_alu;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : hazard_scoreboard_if                                         |
// | Description : ID-stage bundle between decode (master) and the hazard       |
// |               scoreboard (slave).                                          |
// |   master drives: src1, src2, two_src, id_valid, id_wb_en, id_dest,         |
// |                  id_mem_read, fwd_en, flush, mem_ready                     |
// |   slave drives : hazard, issue, stall_count                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W  = hazard_pkg::DEF_REG_ADDR_W,
  parameter int STALL_CNT_W = hazard_pkg::DEF_STALL_CNT_W
);
  logic [REG_ADDR_W-1:0]  src1;
  logic [REG_ADDR_W-1:0]  src2;
  logic                   two_src;
  logic                   id_valid;
  logic                   id_wb_en;
  logic [REG_ADDR_W-1:0]  id_dest;
  logic                   id_mem_read;
  logic                   fwd_en;
  logic                   flush;
  logic                   mem_ready;
  logic                   hazard;
  logic                   issue;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output src1, src2, two_src, id_valid, id_wb_en, id_dest, id_mem_read,
           fwd_en, flush, mem_ready,
    input  hazard, issue, stall_count
  );

  modport slave (
    input  src1, src2, two_src, id_valid, id_wb_en, id_dest, id_mem_read,
           fwd_en, flush, mem_ready,
    output hazard, issue, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_entry                                                 |
// | Description : One scoreboard entry: countdown of cycles until the register |
// |               result is consumable.                                        |
// |   clk, rst  : clock, asynchronous active-high reset                        |
// |   advance   : pipeline moves this cycle (decrement / allow load)           |
// |   load      : a new write to this register issues this cycle               |
// |   load_val  : latency of that new write                                    |
// |   pending   : result not yet available                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] w_dec;

  always_comb begin
    w_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    cnt_d = cnt_q;
    if (advance) begin
      cnt_d = w_dec;
      // A short-latency write must not hide an older, slower write to the
      // same register that is still in flight.
      if (load && (load_val > w_dec)) begin
        cnt_d = load_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pending = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_scoreboard                                            |
// | Description : Per-register pending-write scoreboard for the ID stage.      |
// |               Stalls ID while a source is pending, issues otherwise, and   |
// |               counts stall cycles (saturating).                            |
// |   clk, rst  : clock, asynchronous active-high reset                        |
// |   bus       : hazard_scoreboard_if.slave (ID instruction in, hazard/issue/ |
// |               stall_count out)                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int NOFWD_LAT   = DEF_NOFWD_LAT,
  parameter int FWD_ALU_LAT = DEF_FWD_ALU_LAT,
  parameter int FWD_LD_LAT  = DEF_FWD_LD_LAT,
  parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave bus
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = cnt_w(NOFWD_LAT, FWD_ALU_LAT, FWD_LD_LAT);

  logic [NUM_REGS-1:0]    w_pending;
  logic                   w_active;
  logic                   w_hazard;
  logic                   w_issue;
  logic                   w_wr_issue;
  logic [CNT_W-1:0]       w_load_lat;
  logic [STALL_CNT_W-1:0] stall_count_q;
  logic [STALL_CNT_W-1:0] stall_count_d;

  // Only state from earlier instructions is consulted, so an instruction
  // reading its own destination never stalls on itself.
  assign w_active   = bus.id_valid & ~bus.flush;
  assign w_hazard   = w_active &
                      (w_pending[bus.src1] | (bus.two_src & w_pending[bus.src2]));
  assign w_issue    = w_active & ~w_hazard & bus.mem_ready;
  assign w_wr_issue = w_issue & bus.id_wb_en;
  assign w_load_lat = CNT_W'(sel_lat(bus.fwd_en, bus.id_mem_read,
                                     NOFWD_LAT, FWD_ALU_LAT, FWD_LD_LAT));

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    hazard_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .advance  (bus.mem_ready),
      .load     (w_wr_issue & (bus.id_dest == REG_ADDR_W'(g))),
      .load_val (w_load_lat),
      .pending  (w_pending[g])
    );
  end

  // A frozen pipeline is not a hazard stall; only moving cycles are counted.
  always_comb begin
    stall_count_d = stall_count_q;
    if (bus.mem_ready && w_hazard && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.hazard      = w_hazard;
  assign bus.issue       = w_issue;
  assign bus.stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_scoreboard                                         |
// | Description : Self-checking bench for hazard_scoreboard. A timestamp model  |
// |               (per-register "available at cycle" plus a moving-cycle      |
// |               clock) predicts hazard/issue/stall_count every cycle;       |
// |               directed vectors add literal expectations.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hazard_scoreboard;

  localparam int RAW   = 4;
  localparam int SCW   = 4;
  localparam int NREG  = 2 ** RAW;
  localparam int SMAX  = (2 ** SCW) - 1;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard_if #(.REG_ADDR_W(RAW), .STALL_CNT_W(SCW)) bus ();

  hazard_scoreboard #(
    .REG_ADDR_W  (RAW),
    .NOFWD_LAT   (2),
    .FWD_ALU_LAT (0),
    .FWD_LD_LAT  (1),
    .STALL_CNT_W (SCW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // avail[r]: value of m_now at which register r becomes readable.
  // m_now advances only on cycles where the pipeline moves.
  int m_avail [NREG];
  int m_now;
  int m_stall;

  function automatic logic m_pend(input logic [RAW-1:0] r);
    return m_avail[r] > m_now;
  endfunction

  function automatic logic m_hazard();
    return bus.id_valid & ~bus.flush &
           (m_pend(bus.src1) | (bus.two_src & m_pend(bus.src2)));
  endfunction

  function automatic logic m_issue();
    return bus.id_valid & ~bus.flush & ~m_hazard() & bus.mem_ready;
  endfunction

  function automatic int m_lat();
    if (!bus.fwd_en) return 2;
    return bus.id_mem_read ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_avail[r] <= 0;
      m_now   <= 0;
      m_stall <= 0;
    end else if (bus.mem_ready) begin
      m_now <= m_now + 1;
      if (m_hazard()) m_stall <= (m_stall >= SMAX) ? SMAX : m_stall + 1;
      if (m_issue() && bus.id_wb_en) begin
        if (m_now + 1 + m_lat() > m_avail[bus.id_dest])
          m_avail[bus.id_dest] <= m_now + 1 + m_lat();
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, half a cycle after inputs settle.
  always @(negedge clk) begin
    chk("model_hazard", int'(bus.hazard), int'(m_hazard()));
    chk("model_issue", int'(bus.issue), int'(m_issue()));
    chk("model_stall_count", int'(bus.stall_count), m_stall);
  end

  // ---------------- stimulus ----------------
  task automatic set_id(input logic v, input logic [RAW-1:0] s1, input logic [RAW-1:0] s2,
                        input logic two, input logic wb, input logic [RAW-1:0] dst,
                        input logic mr, input logic fwd, input logic fl, input logic rdy);
    bus.id_valid    = v;
    bus.src1        = s1;
    bus.src2        = s2;
    bus.two_src     = two;
    bus.id_wb_en    = wb;
    bus.id_dest     = dst;
    bus.id_mem_read = mr;
    bus.fwd_en      = fwd;
    bus.flush       = fl;
    bus.mem_ready   = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    set_id(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    set_id(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    rst = 1'b0;

    // Reset state
    peek();
    chk("reset_hazard", int'(bus.hazard), 0);
    chk("reset_issue", int'(bus.issue), 0);
    chk("reset_stall_count", int'(bus.stall_count), 0);
    step();

    // No forwarding: ADD R3, consumer stalls two cycles
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd3, 0, 0, 0, 1);
    peek(); chk("nofwd_add_issue", int'(bus.issue), 1);
    step();
    set_id(1, 4'd3, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1);
    peek(); chk("nofwd_use_c1_hazard", int'(bus.hazard), 1);
    step();
    peek(); chk("nofwd_use_c2_hazard", int'(bus.hazard), 1);
    step();
    peek(); chk("nofwd_use_c3_hazard", int'(bus.hazard), 0);
    chk("nofwd_use_c3_issue", int'(bus.issue), 1);
    step();
    idle(1);
    peek(); chk("nofwd_stall_count", int'(bus.stall_count), 2);
    idle(2);

    // Forwarding: load-use through src2 stalls one cycle
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd5, 1, 1, 0, 1);
    peek(); chk("fwd_ldr_issue", int'(bus.issue), 1);
    step();
    set_id(1, 4'd0, 4'd5, 1, 0, 4'd0, 0, 1, 0, 1);
    peek(); chk("fwd_lduse_c1_hazard", int'(bus.hazard), 1);
    step();
    peek(); chk("fwd_lduse_c2_issue", int'(bus.issue), 1);
    step();
    idle(2);
    // Same with src2 unused
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd5, 1, 1, 0, 1);
    step();
    set_id(1, 4'd0, 4'd5, 0, 0, 4'd0, 0, 1, 0, 1);
    peek(); chk("fwd_src2_unused_hazard", int'(bus.hazard), 0);
    step();
    // ALU result with forwarding never stalls
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd5, 0, 1, 0, 1);
    step();
    set_id(1, 4'd5, 4'd0, 0, 0, 4'd0, 0, 1, 0, 1);
    peek(); chk("fwd_alu_hazard", int'(bus.hazard), 0);
    step();
    idle(2);

    // Memory wait while R7 pending holds everything
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd7, 0, 0, 0, 1);
    step();
    set_id(1, 4'd7, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      peek();
      chk("memwait_hazard", int'(bus.hazard), 1);
      chk("memwait_issue", int'(bus.issue), 0);
      chk("memwait_stall_hold", int'(bus.stall_count), 3);
      step();
    end
    bus.mem_ready = 1'b1;
    peek(); chk("memwait_after_c1_hazard", int'(bus.hazard), 1);
    step();
    peek(); chk("memwait_after_c2_hazard", int'(bus.hazard), 1);
    step();
    peek(); chk("memwait_after_c3_issue", int'(bus.issue), 1);
    step();
    idle(1);
    peek(); chk("memwait_stall_count", int'(bus.stall_count), 5);
    idle(2);

    // Flush suppresses hazard/issue and loads nothing
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd9, 0, 0, 0, 1);
    step();
    set_id(1, 4'd9, 4'd0, 0, 1, 4'd10, 0, 0, 1, 1);
    peek();
    chk("flush_hazard", int'(bus.hazard), 0);
    chk("flush_issue", int'(bus.issue), 0);
    step();
    set_id(1, 4'd10, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1);
    peek(); chk("flush_no_load_hazard", int'(bus.hazard), 0);
    step();
    idle(2);

    // Slow load then fast ALU write to R2: the slower one still governs
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd2, 1, 0, 0, 1);
    step();
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd2, 0, 1, 0, 1);
    peek(); chk("b2b_alu_issue", int'(bus.issue), 1);
    step();
    set_id(1, 4'd2, 4'd0, 0, 0, 4'd0, 0, 1, 0, 1);
    peek(); chk("b2b_keep_max_hazard", int'(bus.hazard), 1);
    step();
    peek(); chk("b2b_release_issue", int'(bus.issue), 1);
    step();
    idle(2);

    // Asynchronous reset mid-operation
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd4, 0, 0, 0, 1);
    step();
    set_id(1, 4'd4, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1);
    peek(); chk("prereset_hazard", int'(bus.hazard), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_hazard", int'(bus.hazard), 0);
    chk("async_reset_stall_count", int'(bus.stall_count), 0);
    step();
    rst = 1'b0;
    peek(); chk("postreset_hazard", int'(bus.hazard), 0);
    step();
    idle(1);

    // Stall counter saturation: self-dependent instruction held in ID
    rst = 1'b1;
    #2 rst = 1'b0;
    set_id(1, 4'd1, 4'd0, 0, 1, 4'd1, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step();
    peek(); chk("sat_stall_after9", int'(bus.stall_count), 6);
    for (int i = 0; i < 21; i++) step();
    peek(); chk("sat_stall_saturated", int'(bus.stall_count), SMAX);
    step();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
